// File: rtl/sdma_xfer_ctrl_pkg.sv
// Shared types and constants for the SDMA transfer controller.
package sdma_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int BLKSZ_W_DEF  = 12;
  localparam int BLKCNT_W_DEF = 16;

  // Boundary code 0 selects a 4 KiB host buffer; each code step doubles it.
  localparam int BOUNDARY_BASE_SHIFT = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sdma_state_e;

endpackage

// File: rtl/sdma_xfer_ctrl_if.sv
// Block request/acknowledge channel between the SDMA sequencer (master)
// and the DMA bus engine (slave).
interface sdma_xfer_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int BLKSZ_W = 12
);
  logic               dma_req;
  logic [ADDR_W-1:0]  dma_addr;
  logic [BLKSZ_W-1:0] dma_len;
  logic               dma_ack;

  modport master (
    output dma_req,
    output dma_addr,
    output dma_len,
    input  dma_ack
  );

  modport slave (
    input  dma_req,
    input  dma_addr,
    input  dma_len,
    output dma_ack
  );
endinterface

// File: rtl/sdma_xfer_ctrl_addr_adv.sv
// Combinational address advance: next block address and host buffer
// boundary crossing detection (a wrap past 2^ADDR_W counts as a crossing).
module sdma_addr_adv
  import sdma_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BLKSZ_W = BLKSZ_W_DEF
) (
  input  logic [ADDR_W-1:0]  cur_addr,
  input  logic [BLKSZ_W-1:0] size,
  input  logic [2:0]         code,
  output logic [ADDR_W-1:0]  next_addr,
  output logic               crossed
);

  logic [ADDR_W:0] sum_d;
  logic [4:0]      shift_d;

  assign sum_d     = {1'b0, cur_addr} + {{(ADDR_W + 1 - BLKSZ_W){1'b0}}, size};
  assign next_addr = sum_d[ADDR_W-1:0];
  assign shift_d   = 5'(BOUNDARY_BASE_SHIFT) + {2'b00, code};
  assign crossed   = sum_d[ADDR_W] | ((cur_addr >> shift_d) != (next_addr >> shift_d));

endmodule

// File: rtl/sdma_xfer_ctrl.sv
// SDMA block transfer sequencer: one DMA request per block, pausing at host
// buffer boundaries. Optional ack watchdog enabled by SDMA_CTRL_TIMEOUT_EN.
module sdma_xfer_ctrl
  import sdma_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int BLKSZ_W     = BLKSZ_W_DEF,
  parameter int BLKCNT_W    = BLKCNT_W_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   sdma_addr,
  input  logic                sdma_addr_wr,
  input  logic [BLKSZ_W-1:0]  blk_size,
  input  logic [BLKCNT_W-1:0] blk_cnt,
  input  logic [2:0]          boundary,
  sdma_xfer_ctrl_if.master    dma,
  output logic                busy,
  output logic                boundary_irq,
  output logic                xfer_done,
  output logic                dma_err,
  output logic [BLKCNT_W-1:0] blocks_left
);

  sdma_state_e         state_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [BLKSZ_W-1:0]  size_q;
  logic [2:0]          code_q;
  logic [BLKCNT_W-1:0] blocks_left_q;
  logic                req_q;
  logic                busy_q;
  logic                irq_q;
  logic                done_q;
  logic                err_q;

  logic [ADDR_W-1:0]   next_addr_d;
  logic                crossed_d;
  logic                tmo_d;
  logic                ack_d;

  assign ack_d = req_q & dma.dma_ack;

  sdma_addr_adv #(
    .ADDR_W  (ADDR_W),
    .BLKSZ_W (BLKSZ_W)
  ) u_addr_adv (
    .cur_addr  (cur_addr_q),
    .size      (size_q),
    .code      (code_q),
    .next_addr (next_addr_d),
    .crossed   (crossed_d)
  );

`ifdef SDMA_CTRL_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] tmr_q;

  // Counts cycles of an outstanding, unacknowledged request.
  always_ff @(posedge clk) begin
    if (reset || state_q != REQ || !req_q || dma.dma_ack || abort) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

  assign tmo_d = req_q && !dma.dma_ack && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_d = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      size_q        <= '0;
      code_q        <= '0;
      blocks_left_q <= '0;
      req_q         <= 1'b0;
      busy_q        <= 1'b0;
      irq_q         <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      irq_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q       <= IDLE;
        req_q         <= 1'b0;
        busy_q        <= 1'b0;
        blocks_left_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              cur_addr_q    <= sdma_addr;
              size_q        <= blk_size;
              code_q        <= boundary;
              blocks_left_q <= blk_cnt;
              busy_q        <= 1'b1;
              if (blk_cnt == '0) begin
                state_q <= DONE;
              end else begin
                state_q <= REQ;
                req_q   <= 1'b1;
              end
            end
          end
          REQ: begin
            if (ack_d) begin
              req_q         <= 1'b0;
              cur_addr_q    <= next_addr_d;
              blocks_left_q <= blocks_left_q - 1'b1;
              // The final block completes the transfer even if it crosses.
              if (blocks_left_q == BLKCNT_W'(1)) begin
                state_q <= DONE;
              end else if (crossed_d) begin
                state_q <= PAUSE;
                irq_q   <= 1'b1;
              end
            end else if (tmo_d) begin
              state_q <= IDLE;
              req_q   <= 1'b0;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else if (!req_q) begin
              req_q <= 1'b1;
            end
          end
          PAUSE: begin
            if (sdma_addr_wr) begin
              cur_addr_q <= sdma_addr;
              state_q    <= REQ;
              req_q      <= 1'b1;
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dma.dma_req   = req_q;
  assign dma.dma_addr  = cur_addr_q;
  assign dma.dma_len   = size_q;
  assign busy          = busy_q;
  assign boundary_irq  = irq_q;
  assign xfer_done     = done_q;
  assign dma_err       = err_q;
  assign blocks_left   = blocks_left_q;

endmodule

// File: tb/tb_sdma_xfer_ctrl.sv
// Self-checking bench for sdma_xfer_ctrl: table-driven transfers plus
// hand-written corner sequences (abort, stall, zero count, watchdog).
module tb_sdma_xfer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] sdma_addr;
  logic        sdma_addr_wr;
  logic [11:0] blk_size;
  logic [15:0] blk_cnt;
  logic [2:0]  boundary;
  logic        busy;
  logic        boundary_irq;
  logic        xfer_done;
  logic        dma_err;
  logic [15:0] blocks_left;

  sdma_xfer_ctrl_if #(.ADDR_W(32), .BLKSZ_W(12)) dma_if ();

  sdma_xfer_ctrl #(
    .ADDR_W      (32),
    .BLKSZ_W     (12),
    .BLKCNT_W    (16),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .sdma_addr    (sdma_addr),
    .sdma_addr_wr (sdma_addr_wr),
    .blk_size     (blk_size),
    .blk_cnt      (blk_cnt),
    .boundary     (boundary),
    .dma          (dma_if.master),
    .busy         (busy),
    .boundary_irq (boundary_irq),
    .xfer_done    (xfer_done),
    .dma_err      (dma_err),
    .blocks_left  (blocks_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]       addr;
    logic [11:0]       size;
    logic [15:0]       cnt;
    logic [2:0]        code;
    logic [31:0]       resume;
    logic [3:0]        n;
    logic [3:0][31:0]  exp;
    logic [1:0]        irqs;
  } vec_t;

  vec_t vecs [7];
  int   errs   = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [11:0] s,
                              input logic [15:0] c, input logic [2:0] code,
                              input logic [31:0] res, input logic [3:0] n,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3,
                              input logic [1:0] irqs);
    vec_t v;
    v.addr = a; v.size = s; v.cnt = c; v.code = code; v.resume = res; v.n = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.irqs = irqs;
    return v;
  endfunction

  task automatic pulse_start(input logic [31:0] a, input logic [11:0] s,
                             input logic [15:0] c, input logic [2:0] code);
    @(negedge clk);
    sdma_addr = a; blk_size = s; blk_cnt = c; boundary = code; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one table transfer with immediate acks and auto-resume on irq.
  task automatic run_vec(input int vi);
    vec_t v;
    int nreq, nirq, ndone;
    v = vecs[vi];
    nreq = 0; nirq = 0; ndone = 0;
    pulse_start(v.addr, v.size, v.cnt, v.code);
    for (int c = 0; c < 80; c++) begin
      if (dma_if.dma_ack) begin
        dma_if.dma_ack = 1'b0;
      end else if (dma_if.dma_req) begin
        if (nreq < int'(v.n)) begin
          chk($sformatf("v%0d req%0d addr", vi, nreq), dma_if.dma_addr, v.exp[nreq]);
          chk($sformatf("v%0d req%0d len", vi, nreq), 32'(dma_if.dma_len), 32'(v.size));
          chk($sformatf("v%0d req%0d blocks_left", vi, nreq), 32'(blocks_left), 32'(v.cnt) - 32'(nreq));
        end
        nreq++;
        dma_if.dma_ack = 1'b1;
      end
      if (sdma_addr_wr) begin
        sdma_addr_wr = 1'b0;
      end else if (boundary_irq) begin
        nirq++;
        sdma_addr = v.resume;
        sdma_addr_wr = 1'b1;
      end
      if (xfer_done) ndone++;
      @(negedge clk);
    end
    dma_if.dma_ack = 1'b0;
    sdma_addr_wr = 1'b0;
    chk($sformatf("v%0d request count", vi), 32'(nreq), 32'(v.n));
    chk($sformatf("v%0d irq count", vi), 32'(nirq), 32'(v.irqs));
    chk($sformatf("v%0d done count", vi), 32'(ndone), 32'd1);
    chk($sformatf("v%0d final blocks_left", vi), 32'(blocks_left), 32'd0);
    chk($sformatf("v%0d final busy", vi), 32'(busy), 32'd0);
    $display("vector %0d: addr=0x%0h size=%0d cnt=%0d code=%0d reqs=%0d irqs=%0d dones=%0d",
             vi, v.addr, v.size, v.cnt, v.code, nreq, nirq, ndone);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  reqn;
    bit  seen_err, seen_done, seen_bad;

    vecs[0] = mk(32'h0000_1000, 12'h200, 16'd4, 3'd0, 32'h0,        4'd4, 32'h1000,     32'h1200, 32'h1400,  32'h1600, 2'd0);
    vecs[1] = mk(32'h0000_1E00, 12'h200, 16'd3, 3'd0, 32'h8000,     4'd3, 32'h1E00,     32'h8000, 32'h8200,  32'h0,    2'd1);
    vecs[2] = mk(32'h0000_1C00, 12'h200, 16'd2, 3'd0, 32'h0,        4'd2, 32'h1C00,     32'h1E00, 32'h0,     32'h0,    2'd0);
    vecs[3] = mk(32'h0000_2E00, 12'h200, 16'd2, 3'd1, 32'h0,        4'd2, 32'h2E00,     32'h3000, 32'h0,     32'h0,    2'd0);
    vecs[4] = mk(32'hFFFF_FE00, 12'h200, 16'd2, 3'd7, 32'h100,      4'd2, 32'hFFFFFE00, 32'h100,  32'h0,     32'h0,    2'd1);
    vecs[5] = mk(32'h0000_3000, 12'h800, 16'd3, 3'd0, 32'h1_0000,   4'd3, 32'h3000,     32'h3800, 32'h1_0000, 32'h0,   2'd1);
    vecs[6] = mk(32'h0000_1F00, 12'h100, 16'd2, 3'd2, 32'h0,        4'd2, 32'h1F00,     32'h2000, 32'h0,     32'h0,    2'd0);

    reset = 1'b1; start = 1'b0; abort = 1'b0; sdma_addr = '0; sdma_addr_wr = 1'b0;
    blk_size = '0; blk_cnt = '0; boundary = '0; dma_if.dma_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset dma_req", 32'(dma_if.dma_req), 32'd0);
    chk("reset dma_addr", dma_if.dma_addr, 32'd0);
    chk("reset dma_len", 32'(dma_if.dma_len), 32'd0);
    chk("reset blocks_left", 32'(blocks_left), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset pulses", {29'd0, boundary_irq, xfer_done, dma_err}, 32'd0);
    $display("reset: checked idle outputs");

    for (int i = 0; i < 7; i++) run_vec(i);

    // Zero block count: done pulse two cycles after start, no request.
    pulse_start(32'h1000, 12'h200, 16'd0, 3'd0);
    chk("cnt0 busy", 32'(busy), 32'd1);
    chk("cnt0 req", 32'(dma_if.dma_req), 32'd0);
    chk("cnt0 early done", 32'(xfer_done), 32'd0);
    @(negedge clk);
    chk("cnt0 done", 32'(xfer_done), 32'd1);
    chk("cnt0 req after", 32'(dma_if.dma_req), 32'd0);
    @(negedge clk);
    chk("cnt0 done one cycle", 32'(xfer_done), 32'd0);
    chk("cnt0 idle", 32'(busy), 32'd0);
    $display("zero count: done pulse observed");

    // start together with abort in IDLE is dropped.
    @(negedge clk);
    sdma_addr = 32'h1000; blk_size = 12'h200; blk_cnt = 16'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start+abort busy", 32'(busy), 32'd0);
    chk("start+abort req", 32'(dma_if.dma_req), 32'd0);
    $display("start with abort: transfer not started");

    // Abort coinciding with the second ack.
    pulse_start(32'h1000, 12'h200, 16'd4, 3'd0);
    chk("abort req1", 32'(dma_if.dma_req), 32'd1);
    dma_if.dma_ack = 1'b1;
    @(negedge clk);
    dma_if.dma_ack = 1'b0;
    @(negedge clk);
    chk("abort req2 addr", dma_if.dma_addr, 32'h1200);
    chk("abort req2 blocks_left", 32'(blocks_left), 32'd3);
    dma_if.dma_ack = 1'b1; abort = 1'b1;
    @(negedge clk);
    dma_if.dma_ack = 1'b0; abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort req", 32'(dma_if.dma_req), 32'd0);
    chk("abort blocks_left", 32'(blocks_left), 32'd0);
    seen_bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (xfer_done || boundary_irq || dma_if.dma_req) seen_bad = 1'b1;
      @(negedge clk);
    end
    chk("abort no done/irq/req", 32'(seen_bad), 32'd0);
    $display("abort with ack: returned to idle");

    // Stalled ack: request held, start and address writes ignored.
    pulse_start(32'h4000, 12'h100, 16'd2, 3'd0);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("stall c%0d req", c), 32'(dma_if.dma_req), 32'd1);
      chk($sformatf("stall c%0d addr", c), dma_if.dma_addr, 32'h4000);
      chk($sformatf("stall c%0d len", c), 32'(dma_if.dma_len), 32'h100);
      start = (c == 3); sdma_addr_wr = (c == 5);
      sdma_addr = 32'h9000; blk_size = 12'h40; blk_cnt = 16'd7;
      @(negedge clk);
    end
    start = 1'b0; sdma_addr_wr = 1'b0;
    chk("stall end addr", dma_if.dma_addr, 32'h4000);
    chk("stall end blocks_left", 32'(blocks_left), 32'd2);
    dma_if.dma_ack = 1'b1;
    @(negedge clk);
    dma_if.dma_ack = 1'b0;
    chk("stall req drops", 32'(dma_if.dma_req), 32'd0);
    chk("stall blocks_left", 32'(blocks_left), 32'd1);
    @(negedge clk);
    chk("stall req2", 32'(dma_if.dma_req), 32'd1);
    chk("stall req2 addr", dma_if.dma_addr, 32'h4100);
    chk("stall req2 len", 32'(dma_if.dma_len), 32'h100);
    dma_if.dma_ack = 1'b1;
    @(negedge clk);
    dma_if.dma_ack = 1'b0;
    chk("stall last blocks_left", 32'(blocks_left), 32'd0);
    chk("stall no early done", 32'(xfer_done), 32'd0);
    @(negedge clk);
    chk("stall done", 32'(xfer_done), 32'd1);
    chk("stall idle", 32'(busy), 32'd0);
    $display("stalled ack: request held stable, done after last ack");

    // Never acknowledge: watchdog behaviour depends on the build.
    pulse_start(32'h5000, 12'h10, 16'd1, 3'd0);
    reqn = 0; seen_err = 1'b0; seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_err; c++) begin
      if (dma_err) seen_err = 1'b1;
      else if (dma_if.dma_req) reqn++;
      if (xfer_done) seen_done = 1'b1;
      @(negedge clk);
    end
`ifdef SDMA_CTRL_TIMEOUT_EN
    chk("timeout err seen", 32'(seen_err), 32'd1);
    chk("timeout request cycles", 32'(reqn), 32'd16);
    chk("timeout err one cycle", 32'(dma_err), 32'd0);
    chk("timeout busy", 32'(busy), 32'd0);
    chk("timeout no done", 32'(seen_done), 32'd0);
`else
    chk("no-timeout err", 32'(seen_err), 32'd0);
    chk("no-timeout request cycles", 32'(reqn), 32'd40);
    chk("no-timeout busy", 32'(busy), 32'd1);
    chk("no-timeout req", 32'(dma_if.dma_req), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("no-timeout abort busy", 32'(busy), 32'd0);
`endif
    $display("unacknowledged request: err_seen=%0d request_cycles=%0d", seen_err, reqn);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
